// File: rtl/btb_update_ctrl.sv
// BTB update writer: mispredict detection with a registered fetch redirect, plus a
// filtered update FIFO drained one entry per cycle. Optional statistics: BTB_UPD_STATS_EN.
module btb_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [31:0]      res_pc_i,
  input  logic [31:0]      res_target_i,
  input  logic             res_taken_i,
  input  logic             res_is_branch_i,
  input  logic             res_pred_hit_i,
  input  logic             res_pred_taken_i,
  input  logic [31:0]      res_pred_tgt_i,
  output logic             mispredict_o,
  output logic [31:0]      redirect_pc_o,
  input  logic             upd_hold_i,
  output logic             update_valid_o,
  output logic [31:0]      update_pc_o,
  output logic [31:0]      update_target_o,
  output logic             update_taken_o,
  output logic             update_is_branch_o,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispred_o
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        is_branch;
  } upd_t;

  upd_t             mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W:0]   count;
  logic             full, empty, accept, push, pop, mispred;
  logic [31:0]      redirect_nxt;

  // The flush cause is the resolving branch itself, so flush carries no extra information here.
  logic unused_flush;
  assign unused_flush = flush_i;

  assign full         = (count == (IDX_W+1)'(DEPTH));
  assign empty        = (count == '0);
  assign res_ready_o  = !full;
  assign accept       = res_valid_i && !full;
  // Not-taken with no BTB entry: nothing to allocate or train.
  assign push         = accept && (res_taken_i || res_pred_hit_i);
  assign pop          = !empty && !upd_hold_i;
  assign mispred      = (res_pred_taken_i != res_taken_i) ||
                        (res_taken_i && (res_pred_tgt_i != res_target_i));
  assign redirect_nxt = res_taken_i ? res_target_i : res_pc_i + 32'd4;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{res_pc_i, res_target_i, res_taken_i, res_is_branch_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + IDX_W'(1);
      if (pop)  rd_ptr <= rd_ptr + IDX_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (IDX_W+1)'(1);
        2'b01:   count <= count - (IDX_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      mispredict_o  <= accept && mispred;
      redirect_pc_o <= (accept && mispred) ? redirect_nxt : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      update_valid_o     <= 1'b0;
      update_pc_o        <= '0;
      update_target_o    <= '0;
      update_taken_o     <= 1'b0;
      update_is_branch_o <= 1'b0;
    end else begin
      update_valid_o <= pop;
      if (pop) begin
        update_pc_o        <= mem[rd_ptr].pc;
        update_target_o    <= mem[rd_ptr].target;
        update_taken_o     <= mem[rd_ptr].taken;
        update_is_branch_o <= mem[rd_ptr].is_branch;
      end
    end
  end

`ifdef BTB_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (accept && (stat_branches_o != '1))           stat_branches_o <= stat_branches_o + CNT_W'(1);
      if (accept && mispred && (stat_mispred_o != '1)) stat_mispred_o  <= stat_mispred_o + CNT_W'(1);
    end
  end
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: vector table plus hand sequences, with a scoreboard of expected BTB updates.
module tb_btb_update_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        is_br;
    logic        hit;
    logic        ptaken;
    logic [31:0] ptgt;
  } res_t;

  typedef struct {
    res_t        r;
    logic        emis;
    logic [31:0] ered;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        is_br;
  } upd_t;

  logic clk = 1'b0, rst_n, flush_i, res_valid_i, res_ready_o;
  logic [31:0] res_pc_i, res_target_i, res_pred_tgt_i, redirect_pc_o;
  logic res_taken_i, res_is_branch_i, res_pred_hit_i, res_pred_taken_i, mispredict_o;
  logic upd_hold_i, update_valid_o, update_taken_o, update_is_branch_o;
  logic [31:0] update_pc_o, update_target_o;
  logic [CNT_W-1:0] stat_branches_o, stat_mispred_o;

  btb_update_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_pc_i(res_pc_i), .res_target_i(res_target_i), .res_taken_i(res_taken_i),
    .res_is_branch_i(res_is_branch_i), .res_pred_hit_i(res_pred_hit_i),
    .res_pred_taken_i(res_pred_taken_i), .res_pred_tgt_i(res_pred_tgt_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .upd_hold_i(upd_hold_i), .update_valid_o(update_valid_o),
    .update_pc_o(update_pc_o), .update_target_o(update_target_o),
    .update_taken_o(update_taken_o), .update_is_branch_o(update_is_branch_o),
    .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
  );

  always #5 clk = ~clk;

  int   nvec = 0, nerr = 0;
  int   mcount = 0;
  logic [CNT_W-1:0] mbr = '0, mmis = '0;
  upd_t sbq[$];
  upd_t last_upd = '0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic br, input logic hit,
                              input logic ptk, input logic [31:0] ptgt);
    res_t r;
    r = '{v, pc, tgt, tk, br, hit, ptk, ptgt};
    return r;
  endfunction

  function automatic logic ref_mis(input res_t r);
    return (r.ptaken != r.taken) || (r.taken && (r.ptgt != r.tgt));
  endfunction

  function automatic logic [31:0] ref_red(input res_t r);
    return r.taken ? r.tgt : r.pc + 32'd4;
  endfunction

  // One clock: drive, advance the model, then check every output after the edge.
  task automatic cyc(input res_t r, input logic hold, input logic flush, input logic rn,
                     input logic emis, input logic [31:0] ered);
    logic acc, popm, push, xmis, xval;
    logic [31:0] xred;
    upd_t got, exp;
    rst_n = rn; flush_i = flush; upd_hold_i = hold;
    res_valid_i = r.valid; res_pc_i = r.pc; res_target_i = r.tgt; res_taken_i = r.taken;
    res_is_branch_i = r.is_br; res_pred_hit_i = r.hit; res_pred_taken_i = r.ptaken;
    res_pred_tgt_i = r.ptgt;
    acc  = rn && r.valid && (mcount != DEPTH);
    popm = rn && (mcount != 0) && !hold;
    xmis = acc && emis;
    xred = xmis ? ered : 32'd0;
    xval = popm;
    if (!rn) begin
      mcount = 0; sbq.delete(); mbr = '0; mmis = '0; last_upd = '0;
    end else begin
      push = acc && (r.taken || r.hit);
      if (push) sbq.push_back('{r.pc, r.tgt, r.taken, r.is_br});
      mcount = mcount + int'(push) - int'(popm);
      if (acc && mbr != '1) mbr = mbr + 1'b1;
      if (xmis && mmis != '1) mmis = mmis + 1'b1;
    end
    @(posedge clk); #1;
    chk("mispredict", 32'(mispredict_o), 32'(xmis));
    chk("redirect_pc", redirect_pc_o, xred);
    chk("res_ready", 32'(res_ready_o), 32'(mcount != DEPTH));
    chk("update_valid", 32'(update_valid_o), 32'(xval));
    if (update_valid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL update_unexpected: got pc %h, scoreboard empty", update_pc_o);
      end else begin
        last_upd = sbq.pop_front();
      end
    end
    got = '{update_pc_o, update_target_o, update_taken_o, update_is_branch_o};
    exp = last_upd;
    chk("update_pc", got.pc, exp.pc);
    chk("update_target", got.tgt, exp.tgt);
    chk("update_taken_isbr", {30'd0, got.taken, got.is_br}, {30'd0, exp.taken, exp.is_br});
`ifdef BTB_UPD_STATS_EN
    chk("stat_branches", stat_branches_o, mbr);
    chk("stat_mispred", stat_mispred_o, mmis);
`else
    chk("stat_branches", stat_branches_o, '0);
    chk("stat_mispred", stat_mispred_o, '0);
`endif
  endtask

  task automatic rcyc(input res_t r, input logic hold);
    cyc(r, hold, 1'b0, 1'b1, ref_mis(r), ref_red(r));
  endtask

  res_t idle;

  initial begin
    idle = '0;
    tbl[0] = '{mk(1, 32'h100, 32'h200, 1, 1, 1, 1, 32'h200), 1'b0, 32'h0};
    tbl[1] = '{mk(1, 32'h104, 32'h0, 0, 1, 1, 1, 32'h180), 1'b1, 32'h108};
    tbl[2] = '{mk(1, 32'h300, 32'h0, 0, 1, 0, 0, 32'h0), 1'b0, 32'h0};
    tbl[3] = '{mk(1, 32'h400, 32'h800, 1, 0, 1, 1, 32'h900), 1'b1, 32'h800};
    tbl[4] = '{mk(1, 32'hFFFFFFFC, 32'h0, 0, 1, 1, 1, 32'h40), 1'b1, 32'h0};
    tbl[5] = '{mk(1, 32'h500, 32'h600, 1, 1, 0, 0, 32'h0), 1'b1, 32'h600};
    tbl[6] = '{mk(0, 32'h900, 32'hA00, 1, 1, 0, 0, 32'h0), 1'b1, 32'hA00};
    tbl[7] = '{mk(1, 32'h700, 32'h740, 1, 1, 1, 1, 32'h700), 1'b1, 32'h740};
    tbl[8] = '{mk(1, 32'h10, 32'h0, 0, 1, 1, 0, 32'h0), 1'b0, 32'h0};
    tbl[9] = '{idle, 1'b0, 32'h0};

    // Reset state
    cyc(idle, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(idle, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Single resolve: update appears two cycles after accept
    rcyc(tbl[0].r, 1'b0);
    rcyc(idle, 1'b0);
    rcyc(idle, 1'b0);

    // Table of resolves, flush toggled to show it has no effect
    for (int i = 0; i < 10; i++) cyc(tbl[i].r, 1'b0, i[0], 1'b1, tbl[i].emis, tbl[i].ered);
    for (int i = 0; i < 4; i++) rcyc(idle, 1'b0);

    // Hold: five back-to-back resolves fill the queue, release drains in order
    for (int i = 0; i < 5; i++) rcyc(mk(1, 32'h1000 + 32'(i*4), 32'h2000 + 32'(i*16), 1, 1, 1, 1,
                                       32'h2000 + 32'(i*16)), 1'b1);
    for (int i = 0; i < 6; i++) rcyc(idle, 1'b0);

    // pc+4 wraps, then reset with two entries queued
    rcyc(mk(1, 32'hFFFFFFFC, 32'h0, 0, 1, 1, 1, 32'h8), 1'b1);
    rcyc(mk(1, 32'h2000, 32'h3000, 1, 1, 1, 1, 32'h3000), 1'b1);
    cyc(idle, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) rcyc(idle, 1'b0);

    // Random traffic with hold, flush and occasional reset
    for (int i = 0; i < 400; i++) begin
      res_t r;
      logic rn;
      r.valid  = ($urandom_range(0, 9) < 7);
      r.pc     = $urandom & 32'hFFFF_FFFC;
      r.tgt    = $urandom & 32'hFFFF_FFFC;
      r.taken  = $urandom_range(0, 1);
      r.is_br  = $urandom_range(0, 1);
      r.hit    = $urandom_range(0, 1);
      r.ptaken = $urandom_range(0, 1);
      r.ptgt   = $urandom_range(0, 1) ? r.tgt : ($urandom & 32'hFFFF_FFFC);
      rn       = ($urandom_range(0, 99) >= 3);
      cyc(r, ($urandom_range(0, 9) < 3), $urandom_range(0, 1), rn, ref_mis(r), ref_red(r));
    end
    for (int i = 0; i < 6; i++) rcyc(idle, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
